// File: rtl/rf_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump_pkg
// Brief    : Shared types and constants for the register-file dump block.
// Revision : 1.0 - initial release
// ============================================================================
package rf_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_READ = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] c_header_byte    = 8'hA5;
    localparam int         c_bytes_per_word = 4;

    function automatic int frame_len(input int depth);
        return 1 + c_bytes_per_word * depth;
    endfunction

    // Frame length at the default depth of 32 registers.
    localparam int c_frame_len = frame_len(32);

endpackage
`default_nettype wire

// File: rtl/rf_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump_if
// Brief    : Register-file read port plus byte-stream handshake for rf_dump.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_dump_if #(
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_CODE_LENGTH = 5
);
    logic                       start;
    logic [REG_CODE_LENGTH-1:0] rd_addr;
    logic [REG_DATA_WIDTH-1:0]  rd_data;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, rd_data, tx_ready,
        output rd_addr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, rd_data, tx_ready,
        input  rd_addr, tx_data, tx_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/rf_dump_ser.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump_ser
// Brief    : Word-to-byte shift register with byte counter, MSB byte first.
// Revision : 1.0 - initial release
// ============================================================================
module rf_dump_ser #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic                  advance,
    output logic [7:0]            byte_out,
    output logic                  last
);
    localparam int c_nbytes = WORD_WIDTH / 8;
    localparam int c_cnt_w  = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;

    logic [WORD_WIDTH-1:0] r_shift;
    logic [c_cnt_w-1:0]    r_byte_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (load) begin
            r_shift    <= i_word;
            r_byte_cnt <= '0;
        end else if (advance) begin
            r_shift    <= {r_shift[WORD_WIDTH-9:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    assign byte_out = r_shift[WORD_WIDTH-1 -: 8];
    assign last     = (r_byte_cnt == c_cnt_w'(c_nbytes - 1));

endmodule
`default_nettype wire

// File: rtl/rf_dump.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump
// Brief    : Streams a header byte then every register word, MSB byte first.
// Revision : 1.0 - initial release
// ============================================================================
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int         REG_DATA_WIDTH  = 32,
    parameter int         REG_DEPTH       = 32,
    parameter int         REG_CODE_LENGTH = 5,
    parameter logic [7:0] HEADER_BYTE     = c_header_byte
) (
    input  logic     clk,
    input  logic     rst,
    rf_dump_if.master bus
);
    state_t                     r_state;
    state_t                     w_next;
    logic [REG_CODE_LENGTH-1:0] r_idx;
    logic                       w_idx_clr;
    logic                       w_idx_inc;
    logic                       w_load;
    logic                       w_advance;
    logic [7:0]                 w_byte;
    logic                       w_last;

    rf_dump_ser #(
        .WORD_WIDTH (REG_DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .i_word   (bus.rd_data),
        .advance  (w_advance),
        .byte_out (w_byte),
        .last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_idx_clr)
                r_idx <= '0;
            else if (w_idx_inc)
                r_idx <= r_idx + 1'b1;
        end
    end

    // tx_valid is a pure function of state, so it cannot retract during a stall.
    always_comb begin
        w_next       = r_state;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next    = S_HDR;
                    w_idx_clr = 1'b1;
                end
            end
            S_HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = HEADER_BYTE;
                bus.busy     = 1'b1;
                if (bus.tx_ready)
                    w_next = S_READ;
            end
            S_READ: begin
                bus.busy = 1'b1;
                w_load   = 1'b1;
                w_next   = S_SEND;
            end
            S_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = w_byte;
                bus.busy     = 1'b1;
                if (bus.tx_ready) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        if (r_idx == REG_CODE_LENGTH'(REG_DEPTH - 1)) begin
                            w_next = S_DONE;
                        end else begin
                            w_idx_inc = 1'b1;
                            w_next    = S_READ;
                        end
                    end
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.rd_addr = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_rf_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_dump
// Brief    : Self-checking bench; a byte-queue frame model checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_dump;
    import rf_dump_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_dump_if #(.REG_DATA_WIDTH(32), .REG_CODE_LENGTH(5)) dif ();

    rf_dump #(
        .REG_DATA_WIDTH  (32),
        .REG_DEPTH       (32),
        .REG_CODE_LENGTH (5),
        .HEADER_BYTE     (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.master)
    );

    logic [31:0] regs [32];
    assign dif.rd_data = regs[dif.rd_addr];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame model: header followed by every register word, MSB byte first.
    logic [7:0] exp_q[$];
    logic [7:0] rx [0:255];
    int         rx_cnt   = 0;
    int         done_cnt = 0;

    task automatic begin_frame();
        exp_q.delete();
        rx_cnt = 0;
        exp_q.push_back(8'hA5);
        for (int n = 0; n < 32; n++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(regs[n][8*b +: 8]);
    endtask

    // tx_ready driver: 0 = always ready, 1 = one high / two low, 2 = held low
    int rmode = 0;
    int ph    = 0;
    initial dif.tx_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rmode)
            1: begin dif.tx_ready = (ph == 0); ph = (ph + 1) % 3; end
            2: dif.tx_ready = 1'b0;
            default: dif.tx_ready = 1'b1;
        endcase
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("no_retract", {31'd0, dif.tx_valid}, 32'd1);
                check("stall_hold", {24'd0, dif.tx_data}, {24'd0, prev_data});
            end
            if (dif.tx_valid) begin
                if (dif.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", {24'd0, dif.tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        check("byte", {24'd0, dif.tx_data}, {24'd0, exp_q.pop_front()});
                    end
                    if (rx_cnt < 256) rx[rx_cnt] = dif.tx_data;
                    rx_cnt++;
                end
                prev_stall = !dif.tx_ready;
                prev_data  = dif.tx_data;
            end else begin
                check("idle_data_zero", {24'd0, dif.tx_data}, 32'd0);
                prev_stall = 1'b0;
            end
            if (dif.done) begin
                done_cnt++;
                check("frame_complete_at_done", exp_q.size(), 32'd0);
            end
        end
    end

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (dif.done) begin cyc = c; break; end
        end
        if (cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int cyc;
    int dbase;

    initial begin
        dif.start = 1'b0;
        for (int n = 0; n < 32; n++) regs[n] = 32'h01010101 * n;

        // Reset state
        rst = 1'b1;
        idle(2);
        check("rst_tx_valid", {31'd0, dif.tx_valid}, 32'd0);
        check("rst_tx_data",  {24'd0, dif.tx_data}, 32'd0);
        check("rst_busy",     {31'd0, dif.busy}, 32'd0);
        check("rst_done",     {31'd0, dif.done}, 32'd0);
        check("rst_rd_addr",  {27'd0, dif.rd_addr}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Full-speed frame and its timing
        begin_frame();
        dbase = done_cnt;
        @(posedge clk); #1;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        @(negedge clk);
        check("valid_cycle_after_start", {31'd0, dif.tx_valid}, 32'd1);
        check("busy_in_hdr", {31'd0, dif.busy}, 32'd1);
        wait_done(400, cyc);
        check("done_cycle", cyc + 1, 32'd162);
        check("t1_bytes", rx_cnt, 32'd129);
        check("t1_rx0",   {24'd0, rx[0]},   32'hA5);
        check("t1_rx4",   {24'd0, rx[4]},   32'h00);
        check("t1_rx5",   {24'd0, rx[5]},   32'h01);
        check("t1_rx125", {24'd0, rx[125]}, 32'h1F);
        check("t1_rx128", {24'd0, rx[128]}, 32'h1F);
        @(negedge clk);
        check("busy_after_done", {31'd0, dif.busy}, 32'd0);
        check("done_one_cycle", {31'd0, dif.done}, 32'd0);
        check("t1_rd_addr_held", {27'd0, dif.rd_addr}, 32'd31);
        idle(3);

        // Stalled frame: 1 high / 2 low
        rmode = 1; ph = 0;
        idle(1);
        begin_frame();
        pulse_start();
        wait_done(1000, cyc);
        check("t2_bytes", rx_cnt, 32'd129);
        rmode = 0;
        idle(3);

        // start ignored mid-frame and in the DONE cycle
        begin_frame();
        dbase = done_cnt;
        pulse_start();
        for (int c = 0; c < 400 && rx_cnt < 50; c++) begin @(posedge clk); #1; end
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int c = 0; c < 400 && !dif.done; c++) begin @(posedge clk); #1; end
        check("t3_in_done", {31'd0, dif.done}, 32'd1);
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dif.tx_valid || dif.busy) begin
                check("t3_no_requeue", 32'd1, 32'd0);
                break;
            end
        end
        check("t3_one_done", done_cnt - dbase, 32'd1);
        check("t3_bytes", rx_cnt, 32'd129);
        idle(2);

        // Reset mid-frame, then a fresh frame
        begin_frame();
        dbase = done_cnt;
        pulse_start();
        for (int c = 0; c < 400 && rx_cnt < 70; c++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("t4_valid", {31'd0, dif.tx_valid}, 32'd0);
        check("t4_busy",  {31'd0, dif.busy}, 32'd0);
        check("t4_addr",  {27'd0, dif.rd_addr}, 32'd0);
        rst = 1'b0;
        idle(3);
        check("t4_no_done", done_cnt - dbase, 32'd0);
        begin_frame();
        pulse_start();
        wait_done(400, cyc);
        check("t4_bytes", rx_cnt, 32'd129);
        check("t4_hdr", {24'd0, rx[0]}, 32'hA5);
        idle(2);

        // Distinctive register word
        regs[11] = 32'hDEADBEEF;
        begin_frame();
        pulse_start();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rx_cnt == 45 && !dif.tx_valid && dif.busy) begin
                check("t5_read_addr", {27'd0, dif.rd_addr}, 32'd11);
                break;
            end
        end
        wait_done(400, cyc);
        check("t5_b45", {24'd0, rx[45]}, 32'hDE);
        check("t5_b46", {24'd0, rx[46]}, 32'hAD);
        check("t5_b47", {24'd0, rx[47]}, 32'hBE);
        check("t5_b48", {24'd0, rx[48]}, 32'hEF);
        regs[11] = 32'h01010101 * 11;
        idle(2);

        // Long stall on the header
        rmode = 2;
        idle(1);
        begin_frame();
        pulse_start();
        begin
            int bad = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (!(dif.tx_valid && dif.tx_data == 8'hA5 && dif.busy && dif.rd_addr == 5'd0))
                    bad++;
            end
            check("t6_hdr_hold", bad, 32'd0);
        end
        check("t6_no_bytes", rx_cnt, 32'd0);
        rmode = 0;
        wait_done(400, cyc);
        check("t6_bytes", rx_cnt, 32'd129);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rf_dump.md
RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 Parameter REG_DATA_WIDTH, default 32: width of one register word.
REQ-002 Parameter REG_DEPTH, default 32: number of registers dumped.
REQ-003 Parameter REG_CODE_LENGTH, default 5: register address width.
REQ-004 Parameter HEADER_BYTE, default 8'hA5: frame start marker.
REQ-005 Port clk, input, 1: single clock; all state changes on posedge clk.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port start, input, 1: dump request, sampled only in IDLE.
REQ-008 Port rd_addr, output, REG_CODE_LENGTH: register file read address.
REQ-009 Port rd_data, input, REG_DATA_WIDTH: combinational read data returned for rd_addr.
REQ-010 Port tx_data, output, 8: byte to byte sink.
REQ-011 Port tx_valid, output, 1: tx_data is valid.
REQ-012 Port tx_ready, input, 1: sink accepts the byte; a transfer occurs when tx_valid and tx_ready are both 1 at posedge clk.
REQ-013 Port busy, output, 1: a dump is in progress.
REQ-014 Port done, output, 1: one-cycle pulse at the end of a dump.

Function
REQ-015 FSM states SHALL be IDLE, HDR, READ, SEND and DONE.
REQ-016 IDLE with start=1 SHALL go to HDR on the next edge, set idx=0 and leave all other transitions unchanged; start=0 stays in IDLE.
REQ-017 HDR SHALL drive tx_valid=1 and tx_data=HEADER_BYTE; on transfer it goes to READ.
REQ-018 READ SHALL last exactly one cycle with rd_addr=idx, capture rd_data into a 32-bit shift register, clear byte_cnt and go to SEND; tx_valid=0 in READ.
REQ-019 SEND SHALL drive tx_valid=1 and tx_data=shift[31:24], sending the word MSB byte first.
REQ-020 On each SEND transfer the shift register SHALL shift left 8 and byte_cnt SHALL increment.
REQ-021 A transfer with byte_cnt=3 SHALL go to DONE if idx=REG_DEPTH-1; otherwise idx increments and the FSM goes to READ.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-023 busy SHALL be 1 in HDR, READ and SEND, and 0 in IDLE and DONE.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable and tx_valid SHALL not drop (no retraction).
REQ-025 start SHALL be ignored outside IDLE; a start=1 in the DONE cycle is not queued.
REQ-026 rd_addr SHALL always equal idx; it is held, not zeroed, between READ cycles.
REQ-027 A complete frame SHALL be 1 header byte + 4*REG_DEPTH bytes, i.e. 129 bytes at default parameters.
REQ-028 Minimum frame time with tx_ready held at 1 SHALL be 1 (HDR) + 32*(1 READ + 4 SEND) + 1 (DONE) = 162 cycles, with tx_valid first high on the cycle after start.
REQ-029 The x0 word SHALL be sent as whatever rd_data returns; the register file returns zero for x0.
REQ-030 tx_data SHALL be 8'h00 whenever tx_valid=0.

Reset
REQ-031 rst=1 at a posedge SHALL force the IDLE state with idx=0, byte_cnt=0, shift=0, tx_valid=0, tx_data=0, busy=0, done=0 and rd_addr=0.
REQ-032 Reset mid-frame SHALL abort the frame with no done pulse; the next start begins a fresh frame from the header.

Structure
REQ-033 The state enum, HEADER_BYTE default and frame-length constant SHALL live in shared package rf_dump_pkg.
REQ-034 The word-to-byte shift register and byte counter SHALL be a sub-module, rf_dump_ser (load, advance, byte_out, last).
REQ-035 rf_dump SHALL connect to a spare register file read port; it SHALL NOT drive the write port.

Verification
REQ-036 Bench SHALL cover: register file model with xN=32'h01010101*N, start pulse, tx_ready=1 -> 129 bytes A5,00,00,00,00,01,01,01,01,...,1F,1F,1F,1F; done at cycle 162.
REQ-037 Bench SHALL cover: tx_ready toggled 1 cycle high / 2 cycles low -> identical byte sequence, tx_data stable across stalls, no valid retraction.
REQ-038 Bench SHALL cover: start pulsed again at byte 50 and on the DONE cycle -> ignored; exactly one frame, one done pulse.
REQ-039 Bench SHALL cover: rst asserted at byte 70 -> next cycle tx_valid=0, busy=0, rd_addr=0; a new start yields a full 129-byte frame starting with A5.
REQ-040 Bench SHALL cover: x11=32'hDEADBEEF -> bytes 45..48 of the frame are DE,AD,BE,EF, with rd_addr=11 during that READ cycle.
REQ-041 Bench SHALL cover: tx_ready=0 held for 100 cycles in HDR -> tx_valid=1, tx_data=A5, busy=1 throughout, with no state advance.
